// File: rtl/bcd_calc_pkg.sv
// Shared constants, state encoding and digit helper for the sequential BCD ALU.
package bcd_calc_pkg;

  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [3:0] nine_digit(input logic [3:0] d);
    return 4'd9 - d;
  endfunction

endpackage

// File: rtl/bcd_alu_seq_if.sv
// Request/response bundle between a requester and the sequential BCD ALU.
interface bcd_alu_seq_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [1:0]            op;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [8*DIGITS-1:0]   result;
  logic                  status;
  logic                  sign;
  logic                  err;

  modport master (output start, op, a, b,
                  input  busy, done, result, status, sign, err);
  modport slave  (input  start, op, a, b,
                  output busy, done, result, status, sign, err);
endinterface

// File: rtl/bcd_digit_add.sv
// One decimal digit of the carry-chained BCD adder; inputs are assumed valid BCD.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] raw;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout = (raw > 5'd9);
    sum  = cout ? 4'(raw + 5'd6) : raw[3:0];
  end
endmodule

// File: rtl/bcd_alu_seq.sv
// Sequential BCD ALU: add/sub/mul/div on packed BCD through one shared 2*DIGITS-digit adder.
// state | meaning
// IDLE  | waiting for start, operands captured on accept
// CALC  | one adder pass (or digit shift) per cycle
// FIX   | ten's complement of a negative SUB result
// DONE  | result valid, done high for this cycle
module bcd_alu_seq
  import bcd_calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic          clk,
  input logic          rst_n,
  bcd_alu_seq_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int RW = 8 * DIGITS;
  localparam int ND = 2 * DIGITS;
  localparam int IW = $clog2(DIGITS_MAX);
  localparam logic [IW-1:0] IDX_TOP = IW'(DIGITS - DIGITS_MIN);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, quo_q, quo_d;
  logic [1:0]      op_q, op_d;
  logic [RW-1:0]   acc_q, acc_d, result_q, result_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            shift_q, shift_d, status_q, status_d, sign_q, sign_d, err_q, err_d;

  logic [RW-1:0]   add_x, add_y, add_s, a_ext, b_ext;
  logic [ND:0]     carry;
  logic            add_cin, add_cout, dig_end;
  logic [3:0]      a_dig, b_dig;

  function automatic logic [RW-1:0] nines(input logic [RW-1:0] v);
    logic [RW-1:0] r;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = nine_digit(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  assign a_ext    = {{W{1'b0}}, a_q};
  assign b_ext    = {{W{1'b0}}, b_q};
  assign carry[0] = add_cin;
  assign add_cout = carry[ND];

  for (genvar g = 0; g < ND; g++) begin : g_dig
    bcd_digit_add u_dig (
      .a   (add_x[4*g +: 4]),
      .b   (add_y[4*g +: 4]),
      .cin (carry[g]),
      .sum (add_s[4*g +: 4]),
      .cout(carry[g+1])
    );
  end

  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
  end

  // Subtraction everywhere is x + nines(y) + 1; carry out means no borrow.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    case (state_q)
      ST_CALC: begin
        case (op_q)
          OP_ADD: begin add_x = a_ext; add_y = b_ext; end
          OP_SUB: begin add_x = a_ext; add_y = nines(b_ext); add_cin = 1'b1; end
          OP_MUL: begin add_x = acc_q; add_y = a_ext; end
          default: begin add_x = acc_q; add_y = nines(b_ext); add_cin = 1'b1; end
        endcase
      end
      ST_FIX: begin add_y = nines(acc_q); add_cin = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    result_d = result_q;
    status_d = status_q;
    sign_d   = sign_q;
    err_d    = err_q;
    dig_end  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          op_d     = bus.op;
          acc_d    = '0;
          quo_d    = '0;
          idx_d    = IDX_TOP;
          cnt_d    = 4'd0;
          shift_d  = 1'b1;
          result_d = '0;
          status_d = 1'b0;
          sign_d   = 1'b0;
          err_d    = 1'b0;
          if (has_bad(bus.a) || has_bad(bus.b)) begin
            err_d    = 1'b1;
            status_d = 1'b1;
            state_d  = ST_DONE;
          end else if (bus.op == OP_DIV && bus.b == '0) begin
            result_d = '1;
            status_d = 1'b1;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        case (op_q)
          OP_ADD: begin
            result_d = add_s;
            status_d = |add_s[RW-1:W];
            state_d  = ST_DONE;
          end
          OP_SUB: begin
            if (add_cout) begin
              result_d = add_s;
              state_d  = ST_DONE;
            end else begin
              acc_d   = add_s;
              state_d = ST_FIX;
            end
          end
          OP_MUL: begin
            if (shift_q) begin
              acc_d   = acc_q << 4;
              cnt_d   = b_dig;
              shift_d = 1'b0;
              dig_end = (b_dig == 4'd0);
            end else begin
              acc_d   = add_s;
              cnt_d   = cnt_q - 4'd1;
              dig_end = (cnt_q == 4'd1);
            end
          end
          default: begin
            if (shift_q) begin
              acc_d   = {acc_q[RW-5:0], a_dig};
              quo_d   = quo_q << 4;
              shift_d = 1'b0;
            end else if (add_cout) begin
              acc_d = add_s;
              quo_d = quo_q + W'(1);
            end else begin
              dig_end = 1'b1;
            end
          end
        endcase
        if (dig_end) begin
          if (idx_q == '0) begin
            state_d = ST_DONE;
            if (op_q == OP_MUL) begin
              result_d = acc_d;
              status_d = |acc_d[RW-1:W];
            end else begin
              result_d = {acc_d[W-1:0], quo_d};
            end
          end else begin
            idx_d   = idx_q - IW'(1);
            shift_d = 1'b1;
          end
        end
      end
      ST_FIX: begin
        result_d = add_s;
        sign_d   = 1'b1;
        status_d = 1'b1;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'b00;
      acc_q    <= '0;
      quo_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= 4'd0;
      shift_q  <= 1'b0;
      result_q <= '0;
      status_q <= 1'b0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      status_q <= status_d;
      sign_q   <= sign_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.status = status_q;
  assign bus.sign   = sign_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_bcd_alu_seq.sv
// Scoreboard bench for bcd_alu_seq (DIGITS=4): integer reference model, queued expectations.
module tb_bcd_alu_seq;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_alu_seq_if #(.DIGITS(D)) bus ();
  bcd_alu_seq #(.DIGITS(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] res;
    logic        st;
    logic        sg;
    logic        er;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int n;
    n = 0;
    for (int i = 3; i >= 0; i--) n = n * 10 + int'(v[4*i +: 4]);
    return n;
  endfunction

  function automatic logic [31:0] int2bcd(input int n);
    logic [31:0] v;
    int m;
    m = n;
    for (int i = 0; i < 8; i++) begin
      v[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return v;
  endfunction

  function automatic int dsum(input int n);
    int s, m;
    s = 0;
    m = n;
    while (m > 0) begin s += m % 10; m = m / 10; end
    return s;
  endfunction

  function automatic bit bad_bcd(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int av, bv, q, r;
    logic [31:0] rb, qb;
    e = '0;
    if (bad_bcd(a) || bad_bcd(b)) begin
      e.er = 1'b1; e.st = 1'b1; e.lat = 1;
      return e;
    end
    av = bcd2int(a);
    bv = bcd2int(b);
    case (op)
      2'd0: begin r = av + bv; e.res = int2bcd(r); e.st = (r > 9999); e.lat = 2; end
      2'd1: begin
        if (av >= bv) begin e.res = int2bcd(av - bv); e.lat = 2; end
        else begin e.res = int2bcd(bv - av); e.sg = 1'b1; e.st = 1'b1; e.lat = 3; end
      end
      2'd2: begin r = av * bv; e.res = int2bcd(r); e.st = (r > 9999); e.lat = 1 + D + dsum(bv); end
      default: begin
        if (bv == 0) begin e.res = 32'hFFFF_FFFF; e.st = 1'b1; e.lat = 1; end
        else begin
          q = av / bv; r = av % bv;
          rb = int2bcd(r); qb = int2bcd(q);
          e.res = {rb[15:0], qb[15:0]};
          e.lat = 1 + 2 * D + dsum(q);
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (bus.done) begin
        chk("done_single_cycle", prev_done, 1'b0);
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: result %h with nothing outstanding", bus.result);
        end else begin
          mon_e = sb.pop_front();
          chk("result", bus.result, mon_e.res);
          chk("status", bus.status, mon_e.st);
          chk("sign", bus.sign, mon_e.sg);
          chk("err", bus.err, mon_e.er);
          chk("latency", cyc - mon_e.acc + 1, mon_e.lat);
        end
      end
      prev_done = bus.done;
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input bit junk);
    exp_t e;
    int   n;
    bit   jk;
    e  = model(op, a, b);
    jk = junk && (e.lat >= 4);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 2'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
    if (e.lat > 1) chk("busy_after_accept", bus.busy, 1'b1);
    if (jk) begin
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
    end
    n = 0;
    while (!bus.done && n < 300) begin @(negedge clk); n++; end
    if (!bus.done) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no done within 300 cycles for op %0d a %h b %h", op, a, b);
      sb.delete();
      return;
    end
    if (jk) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("hold_result", bus.result, e.res);
    chk("hold_status", bus.status, e.st);
    chk("done_dropped", bus.done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_status", bus.status, 1'b0);
    chk("rst_sign", bus.sign, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    #2 rst_n = 1'b1;

    run_op(2'd0, 16'h9999, 16'h0001, 1'b0);
    run_op(2'd1, 16'h0003, 16'h0007, 1'b0);
    run_op(2'd1, 16'h0007, 16'h0003, 1'b0);
    run_op(2'd2, 16'h0012, 16'h0003, 1'b0);
    run_op(2'd2, 16'h9999, 16'h9999, 1'b1);
    run_op(2'd3, 16'h0017, 16'h0005, 1'b0);
    run_op(2'd3, 16'h0017, 16'h0000, 1'b0);
    run_op(2'd0, 16'h00A1, 16'h0003, 1'b0);
    run_op(2'd3, 16'h00A1, 16'h0000, 1'b0);
    run_op(2'd1, 16'h0000, 16'h9999, 1'b0);
    run_op(2'd3, 16'h9999, 16'h0001, 1'b1);

    // Abort a long multiply with an asynchronous reset between clock edges.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd2; bus.a = 16'h9999; bus.b = 16'h9999;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_result", bus.result, 32'h0);
    chk("abort_status", bus.status, 1'b0);
    chk("abort_sign", bus.sign, 1'b0);
    chk("abort_err", bus.err, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(2'd0, 16'h0001, 16'h0001, 1'b0);

    for (int i = 0; i < 80; i++) begin
      logic [1:0]  op;
      logic [15:0] a, b;
      int k;
      op = 2'($urandom_range(0, 3));
      a  = 16'(int2bcd(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 99))));
      b  = 16'(int2bcd(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 99))));
      if ($urandom_range(0, 11) == 0) begin
        k = int'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) a[4*k +: 4] = 4'($urandom_range(10, 15));
        else b[4*k +: 4] = 4'($urandom_range(10, 15));
      end
      if (op == 2'd3 && $urandom_range(0, 7) == 0) b = '0;
      run_op(op, a, b, ($urandom_range(0, 4) == 0));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_alu_seq.md
BCD_ALU_SEQ -- requirements
Module: bcd_alu_seq

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set BCD digits per operand; legal range 1..8.
REQ-002 clk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  in  1  SHALL request an operation; sampled only in IDLE.
REQ-005 op  in  2  SHALL select the operation: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-006 a  in  4*DIGITS  SHALL carry operand A as packed BCD, MS digit at top.
REQ-007 b  in  4*DIGITS  SHALL carry operand B as packed BCD.
REQ-008 busy  out  1  SHALL be high from the cycle after start is accepted until done.
REQ-009 done  out  1  SHALL pulse high for exactly one cycle when the result is valid.
REQ-010 result  out  8*DIGITS  SHALL carry a 2*DIGITS-digit packed BCD result.
REQ-011 status  out  1  SHALL flag carry, borrow, MUL high-half nonzero, div-by-zero, or input error.
REQ-012 sign  out  1  SHALL be high when the SUB result is negative.
REQ-013 err  out  1  SHALL be high when an operand nibble exceeds 9.

Function
REQ-014 FSM states SHALL be IDLE, CALC, FIX, DONE; IDLE->CALC on start; CALC->FIX (SUB, negative only) ->DONE; DONE->IDLE unconditionally.
REQ-015 a, b, op SHALL be registered on the accepting edge; later input changes SHALL NOT affect the operation.
REQ-016 start while busy or in DONE SHALL be ignored.
REQ-017 Latency L SHALL be defined as the edge count from the start-accepting edge to the edge entering DONE; done is high in the cycle following that edge.
REQ-018 All arithmetic SHALL use one 2*DIGITS-digit combinational BCD adder (carry-chained digit adders), one add per CALC cycle.
REQ-019 ADD: L=2; result digit DIGITS SHALL hold the carry (0 or 1), upper digits 0; status=carry.
REQ-020 SUB: A + nines-complement(B) + 1; carry out -> a>=b, L=2, sign=0, status=0.
REQ-021 SUB with a<b: FIX cycle SHALL ten's-complement the raw result to yield magnitude b-a; sign=1, status=1, L=3.
REQ-022 MUL: for each B digit MS first, one shift-left-one-digit cycle then b_i cycles adding A; L = 1 + DIGITS + sum(b_i); status = any of the upper DIGITS digits nonzero.
REQ-023 DIV: for each A digit MS first, one cycle shifting it into remainder R, then trial cycles R-B until borrow (q_i+1 trials); L = 1 + sum(2+q_i).
REQ-024 DIV result SHALL be {remainder, quotient}, DIGITS digits each; status=0.
REQ-025 DIV with b==0: L=1, result all nibbles F, status=1.
REQ-026 Any nibble >9 in a or b: L=1, result 0, err=1, status=1; err check takes precedence over div-by-zero.
REQ-027 result, status, sign, err SHALL hold their values from DONE until the next accepted start, then clear to 0.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, busy=0, done=0, result=0, status=0, sign=0, err=0, all internal registers 0.
REQ-029 Reset mid-operation SHALL abort without a done pulse; the first start after release begins a fresh operation.

Structure
REQ-030 Package bcd_calc_pkg SHALL hold op encoding constants, the FSM state enum, and DIGITS min/max constants.
REQ-031 Sub-module bcd_digit_add (4-bit A, 4-bit B, cin -> 4-bit sum, cout, decimal-corrected) SHALL be instantiated 2*DIGITS times.

Verification (DIGITS=4)
REQ-032 ADD 9999+0001 -> result 0x00010000, status=1, sign=0, L=2.
REQ-033 SUB 0003-0007 -> result 0x00000004, sign=1, status=1, L=3; SUB 0007-0003 -> 0x00000004, sign=0, L=2.
REQ-034 MUL 0012*0003 -> result 0x00000036, status=0, L=8; MUL 9999*9999 -> 0x99980001, status=1.
REQ-035 DIV 0017/0005 -> result 0x00020003, status=0, L=12; DIV 0017/0000 -> 0xFFFFFFFF, status=1, L=1.
REQ-036 a=0x00A1 -> err=1, status=1, result 0, L=1; start pulsed while busy -> ignored, original result unchanged.
REQ-037 rst_n asserted mid-MUL -> all outputs 0 asynchronously, no done; next ADD 0001+0001 -> 0x00000002, L=2.
